// File: rtl/hsstl_rst_pkg.sv
// Shared definitions for the HSST lane reset sequencers: state codes,
// counter width and default sequencing counts.
package hsstl_rst_pkg;

  localparam int unsigned HSST_CNTR_WIDTH = 17;

  localparam int unsigned TX_PMA_CNTR_DEFAULT  = 150;
  localparam int unsigned TX_PLL_STABLE_DEFAULT = 255;
  localparam int unsigned TX_SYNC_CNTR_DEFAULT = 16;
  localparam int unsigned TX_PCS_CNTR_DEFAULT  = 64;

  // TX init FSM codes are exported on tx_init_fsm, so they are fixed values
  localparam logic [2:0] TX_ST_START     = 3'd0;
  localparam logic [2:0] TX_ST_PMA_RST   = 3'd1;
  localparam logic [2:0] TX_ST_WAIT_PLL  = 3'd2;
  localparam logic [2:0] TX_ST_LANE_SYNC = 3'd3;
  localparam logic [2:0] TX_ST_PCS_RST   = 3'd4;
  localparam logic [2:0] TX_ST_DONE      = 3'd5;
  localparam logic [2:0] TX_ST_RATE_CHG  = 3'd6;

  // States in which losing PLL lock forces a return to WAIT_PLL
  function automatic logic tx_lock_guarded(input logic [2:0] st);
    return (st == TX_ST_LANE_SYNC) || (st == TX_ST_PCS_RST) ||
           (st == TX_ST_DONE)      || (st == TX_ST_RATE_CHG);
  endfunction

endpackage

// File: rtl/hsstl_rst4mcrsw_tx_rst_initfsm_if.sv
// Lane-controller side of the TX reset sequencer: status inputs in,
// reset/sync controls and progress out.
interface hsstl_rst4mcrsw_tx_rst_initfsm_if;
  logic       P_TX_LANE_POWERUP;
  logic       pll_lock;
  logic       cur_rate;
  logic [2:0] tx_init_fsm;
  logic       P_TX_PMA_RSTN;
  logic       P_TX_LANE_SYNC;
  logic       P_PCS_TX_RSTN;
  logic       init_done;

  modport master (
    output P_TX_LANE_POWERUP, pll_lock, cur_rate,
    input  tx_init_fsm, P_TX_PMA_RSTN, P_TX_LANE_SYNC, P_PCS_TX_RSTN, init_done
  );

  modport slave (
    input  P_TX_LANE_POWERUP, pll_lock, cur_rate,
    output tx_init_fsm, P_TX_PMA_RSTN, P_TX_LANE_SYNC, P_PCS_TX_RSTN, init_done
  );
endinterface

// File: rtl/hsstl_rst_edge_det.sv
// Generic 1-bit registered change detector: MODE 0 pulses on any toggle,
// MODE 1 on a rising edge only.
module hsstl_rst_edge_det #(
  parameter bit MODE       = 1'b0,
  parameter bit RST_LOAD_D = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic d_q;

  // Loading d during reset keeps a static level from looking like a change
  always_ff @(posedge clk) begin
    if (!rst_n) d_q <= RST_LOAD_D ? d : 1'b0;
    else        d_q <= d;
  end

  assign pulse = MODE ? (d & ~d_q) : (d ^ d_q);

endmodule

// File: rtl/hsstl_rst4mcrsw_tx_rst_initfsm.sv
// Per-lane TX reset sequencer: PMA reset, PLL lock qualification,
// lane-sync pulse, PCS reset release; re-runs on lock loss or rate change.
module hsstl_rst4mcrsw_tx_rst_initfsm
  import hsstl_rst_pkg::*;
#(
  parameter int unsigned CNTR_WIDTH            = HSST_CNTR_WIDTH,
  parameter int unsigned TX_PMA_CNTR_VALUE     = TX_PMA_CNTR_DEFAULT,
  parameter int unsigned PLL_LOCK_STABLE_VALUE = TX_PLL_STABLE_DEFAULT,
  parameter int unsigned TX_SYNC_CNTR_VALUE    = TX_SYNC_CNTR_DEFAULT,
  parameter int unsigned TX_PCS_CNTR_VALUE     = TX_PCS_CNTR_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  hsstl_rst4mcrsw_tx_rst_initfsm_if.slave      tx
);

  localparam logic [CNTR_WIDTH-1:0] PMA_END  = CNTR_WIDTH'(TX_PMA_CNTR_VALUE);
  localparam logic [CNTR_WIDTH-1:0] LOCK_END = CNTR_WIDTH'(PLL_LOCK_STABLE_VALUE);
  localparam logic [CNTR_WIDTH-1:0] SYNC_END = CNTR_WIDTH'(TX_SYNC_CNTR_VALUE);
  localparam logic [CNTR_WIDTH-1:0] PCS_END  = CNTR_WIDTH'(TX_PCS_CNTR_VALUE);
  localparam logic [CNTR_WIDTH-1:0] CNT_ONE  = CNTR_WIDTH'(1);

  logic [2:0]            state;
  logic [CNTR_WIDTH-1:0] cnt;
  logic                  pma_rstn, lane_sync, pcs_rstn, done;
  logic                  rate_tgl;

  hsstl_rst_edge_det #(.MODE(1'b0), .RST_LOAD_D(1'b1)) u_rate_det (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (tx.cur_rate),
    .pulse (rate_tgl)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= TX_ST_START;
      cnt       <= '0;
      pma_rstn  <= 1'b0;
      lane_sync <= 1'b0;
      pcs_rstn  <= 1'b0;
      done      <= 1'b0;
    end else if (state != TX_ST_START && !tx.P_TX_LANE_POWERUP) begin
      state     <= TX_ST_START;
      cnt       <= '0;
      pma_rstn  <= 1'b0;
      lane_sync <= 1'b0;
      pcs_rstn  <= 1'b0;
      done      <= 1'b0;
    end else if (!tx.pll_lock && tx_lock_guarded(state)) begin
      // PMA stays out of reset; only the PCS side is redone after relock
      state     <= TX_ST_WAIT_PLL;
      cnt       <= '0;
      lane_sync <= 1'b0;
      pcs_rstn  <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        TX_ST_START: begin
          cnt       <= '0;
          pma_rstn  <= 1'b0;
          lane_sync <= 1'b0;
          pcs_rstn  <= 1'b0;
          done      <= 1'b0;
          if (tx.P_TX_LANE_POWERUP) state <= TX_ST_PMA_RST;
        end
        TX_ST_PMA_RST: begin
          pma_rstn <= 1'b0;
          if (cnt == PMA_END) begin
            pma_rstn <= 1'b1;
            cnt      <= '0;
            state    <= TX_ST_WAIT_PLL;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        TX_ST_WAIT_PLL: begin
          if (!tx.pll_lock) begin
            cnt <= '0;
          end else if (cnt == LOCK_END) begin
            cnt       <= '0;
            lane_sync <= 1'b1;
            state     <= TX_ST_LANE_SYNC;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        TX_ST_LANE_SYNC: begin
          lane_sync <= 1'b1;
          if (cnt == SYNC_END) begin
            lane_sync <= 1'b0;
            cnt       <= '0;
            state     <= TX_ST_PCS_RST;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        TX_ST_PCS_RST: begin
          pcs_rstn <= 1'b0;
          if (cnt == PCS_END) begin
            pcs_rstn <= 1'b1;
            done     <= 1'b1;
            cnt      <= '0;
            state    <= TX_ST_DONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        TX_ST_DONE: begin
          if (rate_tgl) begin
            pcs_rstn <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            state    <= TX_ST_RATE_CHG;
          end
        end
        TX_ST_RATE_CHG: begin
          pcs_rstn <= 1'b0;
          if (cnt == PCS_END) begin
            cnt       <= '0;
            lane_sync <= 1'b1;
            state     <= TX_ST_LANE_SYNC;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state     <= TX_ST_START;
          cnt       <= '0;
          pma_rstn  <= 1'b0;
          lane_sync <= 1'b0;
          pcs_rstn  <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  assign tx.tx_init_fsm    = state;
  assign tx.P_TX_PMA_RSTN  = pma_rstn;
  assign tx.P_TX_LANE_SYNC = lane_sync;
  assign tx.P_PCS_TX_RSTN  = pcs_rstn;
  assign tx.init_done      = done;

endmodule

// File: tb/tb_hsstl_rst4mcrsw_tx_rst_initfsm.sv
// Directed plus random bench for the TX reset sequencer, checked every cycle
// against a phase/duration model of the sequence.
module tb_hsstl_rst4mcrsw_tx_rst_initfsm;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hsstl_rst4mcrsw_tx_rst_initfsm_if bus ();

  hsstl_rst4mcrsw_tx_rst_initfsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tx    (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: which phase of the bring-up the lane is in and how many
  // cycles that phase still has to run.
  typedef enum int {M_IDLE, M_PMA, M_LOCK, M_SYNC, M_PCS, M_UP, M_RATE} mph_t;
  mph_t ph = M_IDLE;
  int   left = 0;
  int   run  = 0;
  logic rate_prev = 1'b0;

  localparam int PMA_CYC  = 151;
  localparam int LOCK_CYC = 256;
  localparam int SYNC_CYC = 17;
  localparam int PCS_CYC  = 65;

  task automatic model_step();
    logic tgl;
    if (!rst_n) begin
      ph = M_IDLE;
      rate_prev = bus.cur_rate;
    end else begin
      tgl = (bus.cur_rate != rate_prev);
      rate_prev = bus.cur_rate;
      if (ph != M_IDLE && !bus.P_TX_LANE_POWERUP) ph = M_IDLE;
      else if (!bus.pll_lock && (ph == M_SYNC || ph == M_PCS || ph == M_UP || ph == M_RATE)) begin
        ph = M_LOCK; run = 0;
      end else begin
        case (ph)
          M_IDLE: if (bus.P_TX_LANE_POWERUP) begin ph = M_PMA; left = PMA_CYC; end
          M_PMA:  begin left--; if (left == 0) begin ph = M_LOCK; run = 0; end end
          M_LOCK: begin
            run = bus.pll_lock ? run + 1 : 0;
            if (run == LOCK_CYC) begin ph = M_SYNC; left = SYNC_CYC; end
          end
          M_SYNC: begin left--; if (left == 0) begin ph = M_PCS; left = PCS_CYC; end end
          M_PCS:  begin left--; if (left == 0) ph = M_UP; end
          M_UP:   if (tgl) begin ph = M_RATE; left = PCS_CYC; end
          M_RATE: begin left--; if (left == 0) begin ph = M_SYNC; left = SYNC_CYC; end end
          default: ph = M_IDLE;
        endcase
      end
    end
  endtask

  function automatic logic [6:0] exp_vec();
    logic [2:0] code;
    case (ph)
      M_IDLE: code = 3'd0;  M_PMA: code = 3'd1;  M_LOCK: code = 3'd2;
      M_SYNC: code = 3'd3;  M_PCS: code = 3'd4;  M_UP:   code = 3'd5;
      default: code = 3'd6;
    endcase
    return {code, (ph != M_IDLE && ph != M_PMA), (ph == M_SYNC), (ph == M_UP), (ph == M_UP)};
  endfunction

  function automatic logic [6:0] obs_vec();
    return {bus.tx_init_fsm, bus.P_TX_PMA_RSTN, bus.P_TX_LANE_SYNC, bus.P_PCS_TX_RSTN, bus.init_done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("cycle_model", 32'(obs_vec()), 32'(exp_vec()));
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return bus.P_TX_PMA_RSTN;
      1: return bus.P_TX_LANE_SYNC;
      2: return bus.P_PCS_TX_RSTN;
      default: return bus.init_done;
    endcase
  endfunction

  // Ticks until the selected output reaches v; n = -1 on timeout
  task automatic wait_until(input int sel, input logic v, output int n);
    bit hit = 1'b0;
    n = 0;
    while (n < 2000 && !hit) begin
      tick();
      n++;
      hit = (sig(sel) == v);
    end
    if (!hit) n = -1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.P_TX_LANE_POWERUP = 1'b0;
    bus.pll_lock = 1'b1;
    bus.cur_rate = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 32'(obs_vec()), 32'd0);
    rst_n = 1'b1;
    tick();
    check("start_idle", 32'(bus.tx_init_fsm), 32'd0);

    // clean power-up
    bus.P_TX_LANE_POWERUP = 1'b1;
    wait_until(0, 1'b1, n); check("pma_rise_delay", n, 152);
    wait_until(1, 1'b1, n); check("sync_rise_delay", n, 256);
    wait_until(1, 1'b0, n); check("sync_width", n, 17);
    wait_until(3, 1'b1, n); check("done_rise_delay", n, 65);
    check("done_state", 32'({bus.tx_init_fsm, bus.P_PCS_TX_RSTN}), 32'({3'd5, 1'b1}));

    // lock glitch while qualifying lock
    bus.pll_lock = 1'b0; tick();
    check("to_wait_pll", 32'(bus.tx_init_fsm), 32'd2);
    bus.pll_lock = 1'b1;
    repeat (200) tick();
    bus.pll_lock = 1'b0; tick();
    bus.pll_lock = 1'b1;
    wait_until(1, 1'b1, n); check("glitch_sync_delay", n, 256);
    wait_until(3, 1'b1, n); check("glitch_done_delay", n, 82);

    // 10-cycle lock loss in DONE
    bus.pll_lock = 1'b0; tick();
    check("lockloss_outputs", 32'(obs_vec()), 32'({3'd2, 1'b1, 1'b0, 1'b0, 1'b0}));
    repeat (9) tick();
    bus.pll_lock = 1'b1;
    wait_until(3, 1'b1, n); check("relock_done_delay", n, 338);

    // rate change in DONE
    bus.cur_rate = 1'b1; tick();
    check("ratechg_entry", 32'({bus.tx_init_fsm, bus.init_done}), 32'({3'd6, 1'b0}));
    wait_until(1, 1'b1, n); check("ratechg_len", n, 65);
    wait_until(1, 1'b0, n); check("ratechg_sync_width", n, 17);
    wait_until(3, 1'b1, n); check("ratechg_done_delay", n, 65);

    // rate toggle and lock loss together: lock loss wins
    bus.cur_rate = 1'b0; bus.pll_lock = 1'b0; tick();
    check("simul_lock_wins", 32'(bus.tx_init_fsm), 32'd2);
    bus.pll_lock = 1'b1;
    wait_until(3, 1'b1, n); check("simul_done_delay", n, 338);

    // powerup drop in PCS_RST
    bus.cur_rate = 1'b1; tick();
    wait_until(1, 1'b1, n);
    wait_until(1, 1'b0, n);
    check("in_pcs_rst", 32'(bus.tx_init_fsm), 32'd4);
    bus.P_TX_LANE_POWERUP = 1'b0; tick();
    check("powerdown_outputs", 32'(obs_vec()), 32'd0);

    // synchronous reset during LANE_SYNC
    bus.P_TX_LANE_POWERUP = 1'b1;
    wait_until(1, 1'b1, n); check("repower_sync_delay", n, 408);
    repeat (5) tick();
    rst_n = 1'b0; tick();
    check("midsync_reset", 32'(obs_vec()), 32'd0);
    rst_n = 1'b1;

    // random traffic against the model
    repeat (5000) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 2999) == 0) rst_n = 1'b0;
      if (bus.P_TX_LANE_POWERUP) begin
        if ($urandom_range(0, 2499) == 0) bus.P_TX_LANE_POWERUP = 1'b0;
      end else if ($urandom_range(0, 3) == 0) bus.P_TX_LANE_POWERUP = 1'b1;
      if (bus.pll_lock) begin
        if ($urandom_range(0, 399) == 0) bus.pll_lock = 1'b0;
      end else if ($urandom_range(0, 2) == 0) bus.pll_lock = 1'b1;
      if ($urandom_range(0, 119) == 0) bus.cur_rate = ~bus.cur_rate;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
